// File: rtl/mm_stream_reader.sv
// Purpose: Avalon-MM pipelined read master; fetches a contiguous run of words into a show-ahead FIFO.
// Latency: a response at cycle n is visible on out_data/out_valid at n+1; done pulses the cycle after the last response.
// Backpressure: reads issue only while in-flight plus buffered words fit the FIFO, so out_ready stalls throttle mm_read.
//
// Ports:
//   clk, reset                         - single clock, synchronous active-high reset
//   start, start_address, word_count   - transfer request (sampled only in IDLE)
//   busy, done                         - transfer status / one-cycle completion pulse
//   mm_read, mm_address, mm_byteenable - Avalon read request (byte addressed)
//   mm_readdata, mm_waitrequest,
//   mm_readdatavalid                   - Avalon stall and response
//   out_data, out_valid, out_ready     - valid/ready word stream from the FIFO head
module mm_stream_reader #(
    parameter int DATA_WIDTH        = 16,
    parameter int ADDR_WIDTH        = 32,
    parameter int COUNT_WIDTH       = 16,
    parameter int MAX_PENDING_READS = 4,
    parameter int FIFO_DEPTH        = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   start_address,
    input  logic [COUNT_WIDTH-1:0]  word_count,
    output logic                    busy,
    output logic                    done,
    output logic                    mm_read,
    output logic [ADDR_WIDTH-1:0]   mm_address,
    output logic [DATA_WIDTH/8-1:0] mm_byteenable,
    input  logic [DATA_WIDTH-1:0]   mm_readdata,
    input  logic                    mm_waitrequest,
    input  logic                    mm_readdatavalid,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready
);
    localparam int BYTES = DATA_WIDTH / 8;
    // One counter width serves both pending and fifo_count (FIFO_DEPTH >= MAX_PENDING_READS).
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int PW    = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RESP
    } state_t;

    state_t                  state_q, state_nxt;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_nxt;
    logic [COUNT_WIDTH-1:0]  remaining_q, remaining_nxt;
    logic [CW-1:0]           pending_q, pending_nxt;
    logic [CW-1:0]           fifo_count_q, fifo_count_nxt;
    logic                    read_q, read_nxt;
    logic                    done_q, done_nxt;
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];

    logic                    accept;
    logic                    fifo_full;
    logic                    resp_ok;
    logic                    pop;
    logic [CW-1:0]           pend_after;
    logic                    credit;

    assign accept    = read_q && !mm_waitrequest;
    assign fifo_full = (fifo_count_q == CW'(FIFO_DEPTH));
    // Responses with nothing outstanding or no room are dropped (flagged below).
    assign resp_ok   = mm_readdatavalid && (pending_q != '0) && !fifo_full;
    assign pop       = (fifo_count_q != '0) && out_ready;

    // Credit for the next request, from registered counts plus this cycle's accept.
    // Responses arriving this cycle are not credited until they are registered.
    assign pend_after = pending_q + CW'(accept);
    assign credit     = (pend_after < CW'(MAX_PENDING_READS)) &&
                        (((CW+1)'(pend_after) + (CW+1)'(fifo_count_q)) < (CW+1)'(FIFO_DEPTH));

    always_comb begin
        pending_nxt = pending_q;
        case ({accept, resp_ok})
            2'b10:   pending_nxt = pending_q + CW'(1);
            2'b01:   pending_nxt = pending_q - CW'(1);
            default: pending_nxt = pending_q;
        endcase
    end

    always_comb begin
        fifo_count_nxt = fifo_count_q;
        case ({resp_ok, pop})
            2'b10:   fifo_count_nxt = fifo_count_q + CW'(1);
            2'b01:   fifo_count_nxt = fifo_count_q - CW'(1);
            default: fifo_count_nxt = fifo_count_q;
        endcase
    end

    always_comb begin
        state_nxt     = state_q;
        addr_nxt      = addr_q;
        remaining_nxt = remaining_q;
        read_nxt      = read_q;
        done_nxt      = 1'b0;
        case (state_q)
            IDLE: begin
                read_nxt = 1'b0;
                if (start) begin
                    if (word_count != '0) begin
                        addr_nxt      = start_address;
                        remaining_nxt = word_count;
                        state_nxt     = ISSUE;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (accept) begin
                    addr_nxt      = addr_q + ADDR_WIDTH'(BYTES);
                    remaining_nxt = remaining_q - COUNT_WIDTH'(1);
                    if (remaining_q == COUNT_WIDTH'(1)) begin
                        read_nxt  = 1'b0;
                        state_nxt = WAIT_RESP;
                    end else begin
                        read_nxt = credit;
                    end
                end else if (read_q) begin
                    // Request held under waitrequest: address and strobe frozen.
                    read_nxt = 1'b1;
                end else begin
                    read_nxt = credit;
                end
            end
            WAIT_RESP: begin
                read_nxt = 1'b0;
                if (pending_nxt == '0) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                read_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            pending_q    <= '0;
            fifo_count_q <= '0;
            read_q       <= 1'b0;
            done_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_nxt;
            addr_q       <= addr_nxt;
            remaining_q  <= remaining_nxt;
            pending_q    <= pending_nxt;
            fifo_count_q <= fifo_count_nxt;
            read_q       <= read_nxt;
            done_q       <= done_nxt;
            if (resp_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (resp_ok) fifo_mem[wr_ptr_q] <= mm_readdata;
    end

    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign mm_read       = read_q;
    assign mm_address    = addr_q;
    assign mm_byteenable = '1;
    assign out_valid     = (fifo_count_q != '0);
    assign out_data      = out_valid ? fifo_mem[rd_ptr_q] : '0;

    resp_protocol_check: assert property (@(posedge clk) disable iff (reset)
        !(mm_readdatavalid && ((pending_q == '0) || fifo_full)))
        else $error("mm_stream_reader: read response with no pending read or full FIFO, word dropped");

endmodule

// File: tb/tb_mm_stream_reader.sv
module tb_mm_stream_reader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] start_address = '0;
    logic [15:0] word_count = '0;
    logic        busy, done, mm_read;
    logic [31:0] mm_address;
    logic [1:0]  mm_byteenable;
    logic [15:0] mm_readdata = '0;
    logic        mm_waitrequest = 1'b0;
    logic        mm_readdatavalid = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;

    mm_stream_reader dut (
        .clk(clk), .reset(reset), .start(start), .start_address(start_address),
        .word_count(word_count), .busy(busy), .done(done), .mm_read(mm_read),
        .mm_address(mm_address), .mm_byteenable(mm_byteenable), .mm_readdata(mm_readdata),
        .mm_waitrequest(mm_waitrequest), .mm_readdatavalid(mm_readdatavalid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    initial forever #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Responder / consumer configuration set by the tests.
    int resp_lat      = 6;
    int resp_max_pend = 4;
    int ready_mode    = 1;   // 0: never ready, 1: always ready, 2: random

    // Observation logs filled by the monitor.
    int          cyc = 0;
    int          q_due[$];
    logic [15:0] q_dat[$];
    logic [31:0] acc_addr[$];
    int          acc_cyc[$];
    logic [15:0] out_words[$];
    int          done_cyc[$];
    bit          busy_seen, read_seen, prev_stall;
    logic [31:0] prev_addr;
    int          max_out, hold_viol, stall_cnt;

    // memory_sim-style responder (base 16, word = (addr-16)/2) plus stream consumer.
    // Runs just after each falling edge: DUT outputs are stable, inputs are set for the next rising edge.
    initial begin
        logic [31:0] word_addr;
        forever begin
            @(negedge clk); #1;
            cyc = cyc + 1;
            if (reset) begin
                q_due.delete();
                q_dat.delete();
                mm_readdatavalid = 1'b0;
                mm_waitrequest   = 1'b0;
                out_ready        = 1'b0;
                prev_stall       = 1'b0;
            end else begin
                if (prev_stall) begin
                    stall_cnt++;
                    if (!mm_read || mm_address !== prev_addr) hold_viol++;
                end
                if (done)    done_cyc.push_back(cyc);
                if (busy)    busy_seen = 1'b1;
                if (mm_read) read_seen = 1'b1;
                case (ready_mode)
                    0:       out_ready = 1'b0;
                    1:       out_ready = 1'b1;
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
                if (out_valid && out_ready) out_words.push_back(out_data);
                if (q_due.size() > 0 && q_due[0] <= cyc) begin
                    mm_readdatavalid = 1'b1;
                    mm_readdata      = q_dat.pop_front();
                    void'(q_due.pop_front());
                end else begin
                    mm_readdatavalid = 1'b0;
                    mm_readdata      = 16'($urandom);
                end
                mm_waitrequest = (q_due.size() >= resp_max_pend);
                if (mm_read && !mm_waitrequest) begin
                    word_addr = mm_address - 32'd16;
                    q_due.push_back(cyc + resp_lat);
                    q_dat.push_back(word_addr[16:1]);
                    acc_addr.push_back(mm_address);
                    acc_cyc.push_back(cyc);
                end
                if (q_due.size() > max_out) max_out = q_due.size();
                prev_stall = mm_read && mm_waitrequest;
                prev_addr  = mm_address;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        acc_addr.delete(); acc_cyc.delete(); out_words.delete(); done_cyc.delete();
        busy_seen = 1'b0; read_seen = 1'b0;
        max_out = 0; hold_viol = 0; stall_cnt = 0;
    endtask

    task automatic start_xfer(input logic [31:0] a, input logic [15:0] n);
        @(negedge clk);
        start = 1'b1; start_address = a; word_count = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_xfer(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #2;
            if (done_cyc.size() > 0 && out_words.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Reference: word i of a transfer is read from start+2i (mod 2^32) and holds (addr-16)/2.
    function automatic int addr_errs(input logic [31:0] a0, input int n);
        int bad = 0;
        if (acc_addr.size() != n) return -1;
        for (int i = 0; i < n; i++)
            if (acc_addr[i] !== a0 + 32'(2 * i)) bad++;
        return bad;
    endfunction

    function automatic int word_errs(input logic [31:0] a0, input int n);
        int bad = 0;
        logic [31:0] e;
        if (out_words.size() != n) return -1;
        for (int i = 0; i < n; i++) begin
            e = a0 + 32'(2 * i) - 32'd16;
            if (out_words[i] !== e[16:1]) bad++;
        end
        return bad;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        n_assert++; if (mm_read !== 1'b0) begin n_fail++; $display("FAIL reset_mm_read: got %b want 0", mm_read); end
        n_assert++; if (mm_address !== 32'd0) begin n_fail++; $display("FAIL reset_mm_address: got %h want 0", mm_address); end
        n_assert++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
        n_assert++; if (out_valid !== 1'b0 || out_data !== 16'd0) begin n_fail++; $display("FAIL reset_out: got valid %b data %h want 0 0", out_valid, out_data); end
        n_assert++; if (mm_byteenable !== 2'b11) begin n_fail++; $display("FAIL byteenable: got %b want 11", mm_byteenable); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        bit ok;
        int bad;
        clear_logs();
        resp_lat = 6; resp_max_pend = 4; ready_mode = 1;
        start_xfer(32'd26, 16'd5);
        wait_xfer(5, 300, ok);
        repeat (3) @(negedge clk); #2;
        n_assert++; if (!ok) begin n_fail++; $display("FAIL basic_complete: got timeout want done"); end
        bad = addr_errs(32'd26, 5);
        n_assert++; if (bad != 0) begin n_fail++; $display("FAIL basic_addresses: got %0d errors (%0d accepts) want 0", bad, acc_addr.size()); end
        bad = 0;
        for (int i = 1; i < 4 && i < acc_cyc.size(); i++) if (acc_cyc[i] != acc_cyc[0] + i) bad++;
        n_assert++; if (bad != 0) begin n_fail++; $display("FAIL basic_back_to_back: got %0d gaps want 0", bad); end
        bad = word_errs(32'd26, 5);
        n_assert++; if (bad != 0) begin n_fail++; $display("FAIL basic_data: got %0d errors want 0", bad); end
        n_assert++; if (done_cyc.size() != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", done_cyc.size()); end
        n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_fifo_backpressure();
        bit ok;
        int bad;
        clear_logs();
        resp_lat = 6; resp_max_pend = 4; ready_mode = 0;
        start_xfer(32'd16, 16'd12);
        repeat (60) @(negedge clk); #2;
        n_assert++; if (acc_addr.size() != 8) begin n_fail++; $display("FAIL bp_accepts_stalled: got %0d want 8", acc_addr.size()); end
        n_assert++; if (mm_read !== 1'b0) begin n_fail++; $display("FAIL bp_read_low: got %b want 0", mm_read); end
        ready_mode = 1;
        wait_xfer(12, 400, ok);
        n_assert++; if (!ok) begin n_fail++; $display("FAIL bp_complete: got timeout want done"); end
        bad = addr_errs(32'd16, 12);
        n_assert++; if (bad != 0) begin n_fail++; $display("FAIL bp_addresses: got %0d errors want 0", bad); end
        bad = word_errs(32'd16, 12);
        n_assert++; if (bad != 0) begin n_fail++; $display("FAIL bp_data: got %0d errors want 0", bad); end
    endtask

    task automatic test_waitrequest();
        bit ok;
        int bad;
        logic [31:0] a0;
        clear_logs();
        a0 = 32'd16 + 32'(2 * $urandom_range(0, 500));
        resp_lat = 6; resp_max_pend = 2; ready_mode = 2;
        start_xfer(a0, 16'd9);
        wait_xfer(9, 600, ok);
        n_assert++; if (!ok) begin n_fail++; $display("FAIL wr_complete: got timeout want done"); end
        n_assert++; if (stall_cnt == 0) begin n_fail++; $display("FAIL wr_stalls_seen: got 0 want >0"); end
        n_assert++; if (hold_viol != 0) begin n_fail++; $display("FAIL wr_hold_stable: got %0d violations want 0", hold_viol); end
        n_assert++; if (max_out > 4) begin n_fail++; $display("FAIL wr_max_pending: got %0d want <=4", max_out); end
        bad = word_errs(a0, 9);
        n_assert++; if (bad != 0) begin n_fail++; $display("FAIL wr_data: got %0d errors want 0", bad); end
    endtask

    task automatic test_zero_count();
        int s;
        clear_logs();
        ready_mode = 1; resp_lat = 6; resp_max_pend = 4;
        @(negedge clk);
        start = 1'b1; start_address = 32'h100; word_count = 16'd0;
        #2; s = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk); #2;
        n_assert++; if (done_cyc.size() != 1) begin n_fail++; $display("FAIL zero_done_count: got %0d want 1", done_cyc.size()); end
        n_assert++; if (((done_cyc.size() > 0) ? done_cyc[0] : -1) != s + 1) begin n_fail++; $display("FAIL zero_done_timing: got %0d want %0d", (done_cyc.size() > 0) ? done_cyc[0] : -1, s + 1); end
        n_assert++; if (read_seen || busy_seen) begin n_fail++; $display("FAIL zero_no_activity: got read %b busy %b want 0 0", read_seen, busy_seen); end
    endtask

    task automatic test_reset_abort();
        bit ok;
        int bad;
        clear_logs();
        resp_lat = 6; resp_max_pend = 4; ready_mode = 1;
        start_xfer(32'd16, 16'd10);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #2;
            if (acc_addr.size() >= 3) begin ok = 1'b1; break; end
        end
        n_assert++; if (!ok) begin n_fail++; $display("FAIL abort_three_accepts: got %0d want 3", acc_addr.size()); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #2;
        n_assert++; if (mm_read !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_outputs: got read %b busy %b valid %b want 0 0 0", mm_read, busy, out_valid); end
        reset = 1'b0;
        clear_logs();
        start_xfer(32'd16, 16'd2);
        wait_xfer(2, 200, ok);
        repeat (3) @(negedge clk); #2;
        bad = word_errs(32'd16, 2);
        n_assert++; if (!ok || bad != 0) begin n_fail++; $display("FAIL abort_restart_data: got ok %b errors %0d want 1 0", ok, bad); end
        n_assert++; if (done_cyc.size() != 1) begin n_fail++; $display("FAIL abort_restart_done: got %0d want 1", done_cyc.size()); end
    endtask

    task automatic test_start_while_busy();
        bit ok;
        int bad;
        clear_logs();
        resp_lat = 6; resp_max_pend = 4; ready_mode = 1;
        start_xfer(32'd40, 16'd6);
        repeat (3) @(negedge clk);
        start = 1'b1; start_address = 32'd200; word_count = 16'd3;
        @(negedge clk);
        start = 1'b0;
        wait_xfer(6, 300, ok);
        repeat (20) @(negedge clk); #2;
        n_assert++; if (!ok) begin n_fail++; $display("FAIL busy_start_complete: got timeout want done"); end
        bad = addr_errs(32'd40, 6);
        n_assert++; if (bad != 0) begin n_fail++; $display("FAIL busy_start_addresses: got %0d errors (%0d accepts) want 0", bad, acc_addr.size()); end
        bad = word_errs(32'd40, 6);
        n_assert++; if (bad != 0) begin n_fail++; $display("FAIL busy_start_data: got %0d errors want 0", bad); end
        n_assert++; if (done_cyc.size() != 1 || busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_done: got %0d pulses busy %b want 1 0", done_cyc.size(), busy); end
    endtask

    task automatic test_random();
        bit ok;
        int bad, n;
        logic [31:0] a0;
        for (int t = 0; t < 6; t++) begin
            clear_logs();
            n  = $urandom_range(1, 20);
            a0 = 32'd16 + 32'(2 * $urandom_range(0, 1000));
            resp_lat = $urandom_range(1, 8); resp_max_pend = $urandom_range(1, 6); ready_mode = 2;
            start_xfer(a0, 16'(n));
            wait_xfer(n, 1500, ok);
            repeat (3) @(negedge clk); #2;
            bad = word_errs(a0, n);
            n_assert++; if (!ok || bad != 0) begin n_fail++; $display("FAIL rand_data[%0d]: got ok %b errors %0d want 1 0", t, ok, bad); end
            n_assert++; if (max_out > 4 || hold_viol != 0) begin n_fail++; $display("FAIL rand_protocol[%0d]: got max_pend %0d hold_viol %0d want <=4 0", t, max_out, hold_viol); end
            n_assert++; if (done_cyc.size() != 1 || busy !== 1'b0) begin n_fail++; $display("FAIL rand_done[%0d]: got %0d pulses busy %b want 1 0", t, done_cyc.size(), busy); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fifo_backpressure();
        test_waitrequest();
        test_zero_count();
        test_reset_abort();
        test_start_while_busy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mm_stream_reader.md
Name: mm_stream_reader

Overview:
- Avalon-MM pipelined read master that fetches a contiguous run of 16-bit words and delivers them on a valid/ready stream.
- Initiator counterpart of the memory_sim read responder. Used by the display pipeline to prefetch scanline pixel words from frame memory.
- Limits reads in flight and only issues reads that its internal FIFO can absorb, so read data is never lost.

Parameters:
DATA_WIDTH, 16, width of mm_readdata and out_data; address stride per word = DATA_WIDTH/8 bytes
ADDR_WIDTH, 32, byte address width
COUNT_WIDTH, 16, width of word_count
MAX_PENDING_READS, 4, maximum accepted-but-unanswered reads
FIFO_DEPTH, 8, output FIFO entries; power of 2; must be >= MAX_PENDING_READS

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a transfer; sampled only in IDLE
start_address  input  ADDR_WIDTH  byte address of first word; sampled with start
word_count  input  COUNT_WIDTH  number of words to read; sampled with start
busy  output  1  high from the cycle after an accepted start until the last response is received
done  output  1  one-cycle pulse when the transfer completes
mm_read  output  1  Avalon read request
mm_address  output  ADDR_WIDTH  Avalon byte address
mm_byteenable  output  DATA_WIDTH/8  constant all-ones
mm_readdata  input  DATA_WIDTH  Avalon read data
mm_waitrequest  input  1  Avalon stall
mm_readdatavalid  input  1  Avalon response strobe
out_data  output  DATA_WIDTH  FIFO head word
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts the head word when out_valid and out_ready are both high

Behaviour:
- Reset values: mm_read=0, mm_address=0, busy=0, done=0, out_valid=0, out_data=0. On reset, FIFO, pending count and remaining count clear and state goes to IDLE.
- The interface is single clock; reset is synchronous and active-high. Reset mid-transfer aborts immediately, including any read held under waitrequest. The slave is reset in the same cycle, so no post-reset responses are expected.
- States:
  - IDLE: start with word_count>0 latches address and count, then goes to ISSUE. start with word_count=0 pulses done on the next cycle, stays in IDLE, and never asserts busy.
  - ISSUE: issue reads while remaining>0. When the last read is accepted, go to WAIT.
  - WAIT: when pending=0, pulse done, deassert busy, go to IDLE.
  - start is ignored outside IDLE.
- Credit rule: mm_read may rise only when pending < MAX_PENDING_READS and pending + fifo_count < FIFO_DEPTH, with both evaluated on registered state.
- Avalon hold rule: once mm_read is high, mm_read and mm_address stay stable until the cycle with mm_read=1 and mm_waitrequest=0 (accept). No credit re-evaluation happens while held.
- On accept:
  - mm_address += DATA_WIDTH/8, wrapping modulo 2^ADDR_WIDTH.
  - remaining -= 1; pending += 1.
  - Back-to-back accepts, one per cycle, are required when credits allow.
- Responses:
  - mm_readdatavalid pushes mm_readdata into the FIFO and decrements pending.
  - Accept and response in the same cycle leave pending unchanged.
  - Push and pop in the same cycle leave fifo_count unchanged.
- Ordering: responses arrive in request order; the FIFO preserves it.
- FIFO is show-ahead. A response at cycle n gives out_valid=1 with that word at cycle n+1.
- Full FIFO: the credit rule prevents overflow. A response when the FIFO is full, or when pending=0, is a protocol error: the word is dropped and a simulation $error is raised.
- done is asserted on the cycle after the last response is pushed, even if words remain in the FIFO. A new start is accepted while the FIFO still holds data; new words append behind it.

Test Plan:
1. Memory_sim responder (base 16, latency 6, 4 pending, word value = (addr-16)/2), start_address=26, word_count=5, out_ready=1 -> accepts at 26,28,30,32,34 with no gaps; out_data 5,6,7,8,9 in order; exactly one done pulse; busy low afterwards.
2. Same setup, word_count=12, out_ready=0 -> exactly 8 reads accepted, then mm_read stays low. Raise out_ready -> remaining 4 reads issue; stream yields 0..11 with none lost.
3. Responder limited to 2 pending, so it holds waitrequest -> mm_address and mm_read stay constant through every waitrequest cycle; DUT pending never exceeds 4; data still in order.
4. start with word_count=0 -> mm_read never asserted; done high exactly one cycle after start; busy never high.
5. reset asserted after 3 accepts of a 10-word transfer -> next cycle mm_read=0, busy=0, out_valid=0. Then start_address=16, word_count=2 -> out_data 0,1 and done.
6. start pulsed while busy -> ignored; address and count are unchanged and the transfer completes with its original data.
